// File: rtl/ym3438_host_wr_arb.sv
// rtl/ym3438_host_wr_arb.sv - two-requester arbiter for the YM3438 host write port
//
// Purpose: grants one of two level-request write ports (round robin on
// contention) and turns each grant into an address-phase and a data-phase bus
// write towards the ym3438 top, with fixed WR-low widths and idle gaps.
//
// Optional feature: define YM3438_WRARB_ADDR_CACHE_EN to remember the last
// {bank,addr} written and skip the address phase when a grant repeats it.
//
// Ports:
//   MCLK           master clock, rising edge
//   IC             asynchronous active-low reset
//   req0/req1      level write requests, held until the matching ack
//   bank0/bank1    register bank (chip A1) per requester
//   addr0/addr1    register address per requester
//   data0/data1    register data per requester
//   ack0/ack1      one-cycle pulse when the request fields are captured
//   CS, WR, RD     active-low chip strobes (RD tied high)
//   ADDRESS        {A1,A0} to the chip
//   DATA_o         write data to the chip
//   busy           high while a transaction is in progress
//   grant_id       requester owning the current or last transaction

module ym3438_host_wr_arb #(
    parameter int STROBE_CYC = 4,
    parameter int ADDR_GAP   = 16,
    parameter int DATA_GAP   = 96,
    parameter int CNT_W      = 8
) (
    input  logic       MCLK,
    input  logic       IC,
    input  logic       req0,
    input  logic       req1,
    input  logic       bank0,
    input  logic       bank1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [1:0] ADDRESS,
    output logic [7:0] DATA_o,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [2:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_GAP, S_D_SETUP, S_D_STROBE, S_D_GAP
    } state_t;

    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] AGAP_LD   = CNT_W'(ADDR_GAP - 1);
    localparam logic [CNT_W-1:0] DGAP_LD   = CNT_W'(DATA_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             bank_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic             ack0_q, ack1_q, cs_q, wr_q, busy_q, grant_id_q;
    logic [1:0]       address_q;
    logic [7:0]       dout_q;

    // Winner if a grant happens this cycle: the lone requester, or on
    // contention the one that did not win last time.
    logic       gnt_valid;
    logic       gnt_id;
    logic       gnt_bank;
    logic [7:0] gnt_addr;
    logic [7:0] gnt_data;
    logic       cache_hit;

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = (req0 & req1) ? ~last_q : req1;
        gnt_bank  = gnt_id ? bank1 : bank0;
        gnt_addr  = gnt_id ? addr1 : addr0;
        gnt_data  = gnt_id ? data1 : data0;
    end

`ifdef YM3438_WRARB_ADDR_CACHE_EN
    logic       tag_valid_q;
    logic [8:0] tag_q;

    assign cache_hit = tag_valid_q && (tag_q == {gnt_bank, gnt_addr});

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
        end else if (state_q == S_A_GAP && cnt_q == CNT_ZERO) begin
            tag_valid_q <= 1'b1;
            tag_q       <= {bank_q, addr_q};
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            bank_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            cs_q       <= 1'b1;
            wr_q       <= 1'b1;
            busy_q     <= 1'b0;
            grant_id_q <= 1'b0;
            address_q  <= '0;
            dout_q     <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        ack0_q     <= ~gnt_id;
                        ack1_q     <= gnt_id;
                        grant_id_q <= gnt_id;
                        last_q     <= gnt_id;
                        bank_q     <= gnt_bank;
                        addr_q     <= gnt_addr;
                        data_q     <= gnt_data;
                        busy_q     <= 1'b1;
                        cs_q       <= 1'b0;
                        wr_q       <= 1'b1;
                        if (cache_hit) begin
                            state_q   <= S_D_SETUP;
                            address_q <= {gnt_bank, 1'b1};
                            dout_q    <= gnt_data;
                        end else begin
                            state_q   <= S_A_SETUP;
                            address_q <= {gnt_bank, 1'b0};
                            dout_q    <= gnt_addr;
                        end
                    end
                end
                S_A_SETUP, S_D_SETUP: begin
                    state_q <= (state_q == S_A_SETUP) ? S_A_STROBE : S_D_STROBE;
                    wr_q    <= 1'b0;
                    cnt_q   <= STROBE_LD;
                end
                S_A_STROBE, S_D_STROBE: begin
                    // WR rises on entry to the gap; CS follows one cycle later.
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= (state_q == S_A_STROBE) ? S_A_GAP : S_D_GAP;
                        wr_q    <= 1'b1;
                        cnt_q   <= (state_q == S_A_STROBE) ? AGAP_LD : DGAP_LD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_A_GAP: begin
                    cs_q <= 1'b1;
                    if (cnt_q == CNT_ZERO) begin
                        state_q   <= S_D_SETUP;
                        cs_q      <= 1'b0;
                        address_q <= {bank_q, 1'b1};
                        dout_q    <= data_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_D_GAP: begin
                    cs_q <= 1'b1;
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign CS       = cs_q;
    assign WR       = wr_q;
    assign RD       = 1'b1;
    assign ADDRESS  = address_q;
    assign DATA_o   = dout_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_ym3438_host_wr_arb.sv
// tb/tb_ym3438_host_wr_arb.sv - self-checking bench for ym3438_host_wr_arb
module tb_ym3438_host_wr_arb;

    logic MCLK = 1'b0;
    logic IC   = 1'b0;

    logic       req0_v[2], req1_v[2], bank0_v[2], bank1_v[2];
    logic [7:0] addr0_v[2], addr1_v[2], data0_v[2], data1_v[2];
    logic       ack0_o[2], ack1_o[2], cs_o[2], wr_o[2], rd_o[2], busy_o[2], gid_o[2];
    logic [1:0] addr_o[2];
    logic [7:0] dat_o[2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 MCLK = ~MCLK;

    ym3438_host_wr_arb dut0 (
        .MCLK(MCLK), .IC(IC),
        .req0(req0_v[0]), .req1(req1_v[0]), .bank0(bank0_v[0]), .bank1(bank1_v[0]),
        .addr0(addr0_v[0]), .addr1(addr1_v[0]), .data0(data0_v[0]), .data1(data1_v[0]),
        .ack0(ack0_o[0]), .ack1(ack1_o[0]), .CS(cs_o[0]), .WR(wr_o[0]), .RD(rd_o[0]),
        .ADDRESS(addr_o[0]), .DATA_o(dat_o[0]), .busy(busy_o[0]), .grant_id(gid_o[0])
    );

    ym3438_host_wr_arb #(.STROBE_CYC(1), .ADDR_GAP(1), .DATA_GAP(1)) dut1 (
        .MCLK(MCLK), .IC(IC),
        .req0(req0_v[1]), .req1(req1_v[1]), .bank0(bank0_v[1]), .bank1(bank1_v[1]),
        .addr0(addr0_v[1]), .addr1(addr1_v[1]), .data0(data0_v[1]), .data1(data1_v[1]),
        .ack0(ack0_o[1]), .ack1(ack1_o[1]), .CS(cs_o[1]), .WR(wr_o[1]), .RD(rd_o[1]),
        .ADDRESS(addr_o[1]), .DATA_o(dat_o[1]), .busy(busy_o[1]), .grant_id(gid_o[1])
    );

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Bus levels at offset tp into a transaction; tp counts from the
    // address-phase setup cycle (a cache hit starts at the data setup offset).
    function automatic logic [11:0] expect_bus(input int tp, input int s, input int ag,
                                               input logic b, input logic [7:0] a,
                                               input logic [7:0] d);
        int u;
        logic [1:0] ad;
        logic [7:0] dt;
        logic ecs, ewr;
        if (tp < 1 + s + ag) begin
            u = tp; ad = {b, 1'b0}; dt = a;
        end else begin
            u = tp - (1 + s + ag); ad = {b, 1'b1}; dt = d;
        end
        ecs = (u <= s + 1) ? 1'b0 : 1'b1;
        ewr = (u >= 1 && u <= s) ? 1'b0 : 1'b1;
        return {ecs, ewr, ad, dt};
    endfunction

    // Request lines as the DUT saw them at the last rising edge.
    logic       s_r0[2], s_r1[2], s_b0[2], s_b1[2];
    logic [7:0] s_a0[2], s_a1[2], s_d0[2], s_d1[2];
    always @(posedge MCLK) begin
        for (int i = 0; i < 2; i++) begin
            s_r0[i] <= req0_v[i]; s_r1[i] <= req1_v[i];
            s_b0[i] <= bank0_v[i]; s_b1[i] <= bank1_v[i];
            s_a0[i] <= addr0_v[i]; s_a1[i] <= addr1_v[i];
            s_d0[i] <= data0_v[i]; s_d1[i] <= data1_v[i];
        end
    end

    bit         m_act[2];
    int         m_tp[2];
    logic       m_b[2], m_id[2], m_last[2], m_tv[2];
    logic [7:0] m_a[2], m_d[2], m_dt[2];
    logic [1:0] m_ad[2];
    logic [8:0] m_tag[2];

    always @(negedge MCLK) begin
        int s, ag, dg, ta;
        logic [11:0] bus;
        logic [1:0] eack;
        logic ecs, ewr;
        bit hit;
        for (int i = 0; i < 2; i++) begin
            s  = (i == 0) ? 4 : 1;
            ag = (i == 0) ? 16 : 1;
            dg = (i == 0) ? 96 : 1;
            ta = 1 + s + ag;
            eack = 2'b00;
            if (!IC) begin
                m_act[i] = 0; m_last[i] = 1'b1; m_id[i] = 1'b0;
                m_ad[i] = '0; m_dt[i] = '0; m_tv[i] = 1'b0; m_tag[i] = '0;
            end else if (m_act[i]) begin
                m_tp[i]++;
                if (m_tp[i] == ta) begin
                    m_tv[i] = 1'b1; m_tag[i] = {m_b[i], m_a[i]};
                end
                if (m_tp[i] == ta + 1 + s + dg) m_act[i] = 0;
            end else if (s_r0[i] || s_r1[i]) begin
                m_id[i]   = (s_r0[i] && s_r1[i]) ? ~m_last[i] : s_r1[i];
                m_last[i] = m_id[i];
                m_b[i] = m_id[i] ? s_b1[i] : s_b0[i];
                m_a[i] = m_id[i] ? s_a1[i] : s_a0[i];
                m_d[i] = m_id[i] ? s_d1[i] : s_d0[i];
                hit = 0;
`ifdef YM3438_WRARB_ADDR_CACHE_EN
                hit = m_tv[i] && (m_tag[i] == {m_b[i], m_a[i]});
`endif
                m_tp[i]  = hit ? ta : 0;
                m_act[i] = 1;
                eack[m_id[i]] = 1'b1;
            end
            ecs = 1'b1; ewr = 1'b1;
            if (m_act[i]) begin
                bus = expect_bus(m_tp[i], s, ag, m_b[i], m_a[i], m_d[i]);
                ecs = bus[11]; ewr = bus[10]; m_ad[i] = bus[9:8]; m_dt[i] = bus[7:0];
            end
            chk("CS", i, cs_o[i], ecs);
            chk("WR", i, wr_o[i], ewr);
            chk("RD", i, rd_o[i], 1);
            chk("ADDRESS", i, addr_o[i], m_ad[i]);
            chk("DATA_o", i, dat_o[i], m_dt[i]);
            chk("busy", i, busy_o[i], m_act[i] ? 1 : 0);
            chk("grant_id", i, gid_o[i], m_id[i]);
            chk("ack0", i, ack0_o[i], eack[0]);
            chk("ack1", i, ack1_o[i], eack[1]);
        end
    end

    // Call just after a falling edge: req0 is raised now, k counts falling
    // edges from there.
    task automatic single(input int i, input logic b, input logic [7:0] a, input logic [7:0] d,
                          output int ack_k, output int fall_k, output int a_low,
                          output int d_low, output int a_hi);
        ack_k = -1; fall_k = -1; a_low = 0; d_low = 0; a_hi = 0;
        bank0_v[i] = b; addr0_v[i] = a; data0_v[i] = d; req0_v[i] = 1'b1;
        for (int k = 1; k <= 300 && fall_k < 0; k++) begin
            @(negedge MCLK);
            if (ack0_o[i] && ack_k < 0) begin
                ack_k = k; req0_v[i] = 1'b0;
            end
            if (busy_o[i]) begin
                if (!wr_o[i] && addr_o[i] == {b, 1'b0} && dat_o[i] == a) a_low++;
                if (!wr_o[i] && addr_o[i] == {b, 1'b1} && dat_o[i] == d) d_low++;
                if (wr_o[i] && addr_o[i] == {b, 1'b0}) a_hi++;
            end else if (k > 1) begin
                fall_k = k;
            end
        end
        req0_v[i] = 1'b0;
    endtask

    // Two requesters on dut0; req1 rises d1 falling edges after req0.
    task automatic both(input int d1, output int k0, output int k1, output int kf);
        k0 = -1; k1 = -1; kf = -1;
        addr0_v[0] = 8'h11; data0_v[0] = 8'h22; bank0_v[0] = 1'b0;
        addr1_v[0] = 8'h33; data1_v[0] = 8'h44; bank1_v[0] = 1'b1;
        req0_v[0] = 1'b1;
        if (d1 == 0) req1_v[0] = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge MCLK);
            if (k == d1) req1_v[0] = 1'b1;
            if (ack0_o[0] && k0 < 0) begin k0 = k; req0_v[0] = 1'b0; end
            if (ack1_o[0] && k1 < 0) begin k1 = k; req1_v[0] = 1'b0; end
            if (!busy_o[0] && kf < 0 && k > 1) kf = k;
            if (k0 > 0 && k1 > 0 && k > k1 && !busy_o[0]) break;
        end
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge MCLK); #2 IC = 1'b0;
        @(negedge MCLK); @(negedge MCLK); #2 IC = 1'b1;
        @(negedge MCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ak, fk, al, dl, ah, k0, k1, kf;
        for (int i = 0; i < 2; i++) begin
            req0_v[i] = 0; req1_v[i] = 0; bank0_v[i] = 0; bank1_v[i] = 0;
            addr0_v[i] = 0; addr1_v[i] = 0; data0_v[i] = 0; data1_v[i] = 0;
        end
        @(negedge MCLK); @(negedge MCLK);
        chk("reset CS", 0, cs_o[0], 1);
        chk("reset WR", 0, wr_o[0], 1);
        chk("reset busy", 0, busy_o[0], 0);
        #2 IC = 1'b1;
        @(negedge MCLK);

        single(0, 1'b1, 8'h30, 8'h71, ak, fk, al, dl, ah);
        chk("single ack cycle", 0, ak, 1);
        chk("single busy fall", 0, fk, 123);
        chk("single addr WR-low", 0, al, 4);
        chk("single data WR-low", 0, dl, 4);
        chk("single addr setup+gap", 0, ah, 17);

        do_reset();
        both(0, k0, k1, kf);
        chk("both first ack0", 0, k0, 1);
        chk("both first idle", 0, kf, 123);
        chk("both first ack1", 0, k1, 124);
        both(0, k0, k1, kf);
        chk("both second ack0", 0, k0, 1);
        chk("both second ack1", 0, k1, 124);

        @(negedge MCLK);
        both(4, k0, k1, kf);
        chk("mid ack0", 0, k0, 1);
        chk("mid idle", 0, kf, 123);
        chk("mid ack1", 0, k1, 124);

        @(negedge MCLK);
        addr0_v[0] = 8'h40; data0_v[0] = 8'h55; bank0_v[0] = 1'b0; req0_v[0] = 1'b1;
        @(negedge MCLK); req0_v[0] = 1'b0;
        @(negedge MCLK); @(negedge MCLK);
        #2 IC = 1'b0;
        #1;
        chk("abort CS", 0, cs_o[0], 1);
        chk("abort WR", 0, wr_o[0], 1);
        chk("abort busy", 0, busy_o[0], 0);
        @(negedge MCLK); #2 IC = 1'b1;
        @(negedge MCLK);
        single(0, 1'b0, 8'h40, 8'h55, ak, fk, al, dl, ah);
        chk("post-abort ack", 0, ak, 1);
        chk("post-abort fall", 0, fk, 123);

        @(negedge MCLK);
        single(1, 1'b0, 8'h5A, 8'hA5, ak, fk, al, dl, ah);
        chk("small ack", 1, ak, 1);
        chk("small busy width", 1, fk - 1, 6);
        chk("small addr WR-low", 1, al, 1);
        chk("small data WR-low", 1, dl, 1);

        do_reset();
        single(0, 1'b0, 8'h28, 8'h01, ak, fk, al, dl, ah);
        chk("repeat first fall", 0, fk, 123);
        @(negedge MCLK);
        single(0, 1'b0, 8'h28, 8'h02, ak, fk, al, dl, ah);
`ifdef YM3438_WRARB_ADDR_CACHE_EN
        chk("cached fall", 0, fk, 102);
        chk("cached addr WR-low", 0, al, 0);
`else
        chk("uncached fall", 0, fk, 123);
        chk("uncached addr WR-low", 0, al, 4);
`endif
        chk("repeat data WR-low", 0, dl, 4);
        do_reset();
        single(0, 1'b0, 8'h28, 8'h03, ak, fk, al, dl, ah);
        chk("after reset fall", 0, fk, 123);
        chk("after reset addr WR-low", 0, al, 4);

        @(negedge MCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
